cve2_instr_mem_responder: RTL
=============================

# cve2_instr_mem_responder

Instruction-side memory responder for the core's fetch interface (`instr_req`/`instr_gnt`/`instr_rvalid`). It is the slave end of the fetch protocol. It grants fetch requests, issues reads to a single-port synchronous instruction SRAM, and returns in-order responses with `rdata`/`err`. Pipelined requests are supported up to a bounded outstanding depth. It sits between the core fetch port and the on-chip instruction memory macro.

## Interface
- `MEM_AW`, default 10: SRAM word-address width (capacity 2^MEM_AW 32-bit words).
- `BASE_ADDR`, default 32'h0000_0000: byte base address of the memory window. Must be 4·2^MEM_AW aligned.
- `MEM_LATENCY`, default 1: SRAM read latency in cycles, legal range 1..3.
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered requests, legal range 1..4.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in 32: fetch byte address. Bits [1:0] are ignored.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: response valid.
- `instr_rdata_o` out 32: response data.
- `instr_err_o` out 1: response error.
- `stall_i` in 1: memory port taken by another master; suppresses grant.
- `mem_req_o` out 1: SRAM read enable.
- `mem_addr_o` out MEM_AW: SRAM word address.
- `mem_rdata_i` in 32: SRAM read data, valid MEM_LATENCY cycles after `mem_req_o`.
- `busy_o` out 1: at least one request in flight.

## Operation
- Outstanding counter `cnt_q` (width clog2(MAX_OUTSTANDING+1)): increments on a grant, decrements on `instr_rvalid_o`. Both in the same cycle leave it unchanged.
- Grant (combinational): `instr_gnt_o = instr_req_i & ~stall_i & (cnt_q < MAX_OUTSTANDING | instr_rvalid_o)`. At full, a retiring response frees a slot in the same cycle.
- Range check: `hit = (instr_addr_i - BASE_ADDR) < 4·2^MEM_AW`, using 32-bit unsigned subtraction, so addresses below the base wrap and miss.
- `mem_req_o = instr_gnt_o & hit`. `mem_addr_o = (instr_addr_i - BASE_ADDR)[MEM_AW+1:2]`.
- Response pipeline: a MEM_LATENCY-stage shift register of {valid, err}. Stage 0 loads {`instr_gnt_o`, `instr_gnt_o & ~hit`}. The last stage drives `instr_rvalid_o` and `instr_err_o`.
- `instr_rdata_o = mem_rdata_i` when `instr_rvalid_o & ~instr_err_o`, otherwise 32'h0.
- Responses always return in grant order. The protocol has no response backpressure.
- `busy_o = (cnt_q != 0)`.
- The initiator may withdraw or change an ungranted request. No state changes without a grant.

## Timing
- Reset values: `instr_gnt_o` follows inputs (0 while `instr_req_i`=0). `instr_rvalid_o`=0, `instr_err_o`=0, `instr_rdata_o`=0, `mem_req_o`=0, `busy_o`=0, `cnt_q`=0, pipeline cleared.
- Latency: a grant at cycle T gives `instr_rvalid_o` at T+MEM_LATENCY, for both hits and misses.
- Throughput: one response per cycle when MEM_LATENCY ≤ MAX_OUTSTANDING. Otherwise at most MAX_OUTSTANDING grants per MEM_LATENCY cycles.
- `stall_i` affects only grant. Responses already in flight complete unaffected.
- Reset asserted mid-operation: all in-flight responses are dropped, and `instr_rvalid_o`=0 from the reset edge onward. No SRAM data is forwarded after reset releases.
- Simultaneous grant and response at `cnt_q`=MAX_OUTSTANDING: legal, count is unchanged.
- Address at the top word of the window (BASE + 4·2^MEM_AW − 4) is a hit. The next word is a miss.

## Configuration
- `CVE2_IMEM_RANGE_CHECK_EN` defined: range check as above. Misses give `instr_err_o`=1 with rdata 0 and no SRAM access.
- Not defined: `hit` is forced to 1. Addresses alias modulo the window (`mem_addr_o = instr_addr_i[MEM_AW+1:2]`, BASE_ADDR ignored), and `instr_err_o` is tied 0.

## Test plan
- Single fetch, MEM_LATENCY=1, BASE=0: request at 0x10 with SRAM word 4 = 32'hDEAD_BEEF. Grant at T, `mem_addr_o`=4, then rvalid at T+1 with rdata DEAD_BEEF and err 0.
- Back-to-back pipelining, MEM_LATENCY=2, MAX=2: continuous requests at 0x0, 0x4, 0x8, 0xC. Grants every cycle, rvalid on four consecutive cycles starting T+2, data in order, `cnt_q` never above 2.
- Outstanding limit, MEM_LATENCY=3, MAX=2: continuous requests give grants at T and T+1, none at T+2. A grant is re-allowed at T+3 coincident with the first rvalid.
- Range error (macro on), MEM_AW=10, BASE=0x1000: request at 0x2000 gives a grant, `mem_req_o`=0, and rvalid at T+1 with err 1 and rdata 0. A request at 0x1FFC is a hit.
- Stall and withdraw: `stall_i`=1 with a request at 0x8 for 3 cycles gives no grant, no mem_req, and `cnt_q`=0. The address then changes to 0xC with `stall_i`=0, and the response carries word 3.
- Reset mid-flight: grant at T, `rst_i` pulsed at T+0.5 (MEM_LATENCY=2). No rvalid appears at T+2, and `busy_o`=0 after the pulse.

Source files
------------

// File: rtl/cve2_instr_mem_responder.sv
// Fetch-side slave that grants core fetches and returns in-order responses from an instruction SRAM.
// Define CVE2_IMEM_RANGE_CHECK_EN to error out fetches outside the BASE_ADDR window.
module cve2_instr_mem_responder #(
    parameter int unsigned MEM_AW          = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned        CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic [MEM_LATENCY-1:0] err_q, err_d;
    logic [31:0]            offset;
    logic                   hit;
    logic                   unused_addr_bits;

    assign offset = instr_addr_i - BASE_ADDR;

`ifdef CVE2_IMEM_RANGE_CHECK_EN
    localparam logic [32:0] WIN_BYTES = 33'd1 << (MEM_AW + 2);

    // Unsigned wrap makes addresses below the base land far above the window.
    assign hit              = ({1'b0, offset} < WIN_BYTES);
    assign mem_addr_o       = offset[MEM_AW+1:2];
    assign unused_addr_bits = ^offset[1:0];
`else
    assign hit              = 1'b1;
    assign mem_addr_o       = instr_addr_i[MEM_AW+1:2];
    assign unused_addr_bits = ^{offset, instr_addr_i[1:0], instr_addr_i[31:MEM_AW+2]};
`endif

    // A response retiring this cycle frees a slot for a same-cycle grant.
    assign instr_gnt_o    = instr_req_i & ~stall_i & ((cnt_q < CNT_MAX) | instr_rvalid_o);
    assign mem_req_o      = instr_gnt_o & hit;
    assign instr_rvalid_o = vld_q[MEM_LATENCY-1];
    assign instr_err_o    = err_q[MEM_LATENCY-1];
    assign instr_rdata_o  = (instr_rvalid_o & ~instr_err_o) ? mem_rdata_i : 32'h0;
    assign busy_o         = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        vld_d    = vld_q;
        err_d    = err_q;
        vld_d[0] = instr_gnt_o;
        err_d[0] = instr_gnt_o & ~hit;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            vld_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

endmodule
